// File: rtl/crc_stream_engine_pkg.sv
// crc_pkg: shared FSM state type and standard CRC polynomials
// for crc_stream_engine and its LFSR step datapath.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SHIFT,
    DONE
  } crc_state_e;

  localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [7:0]  CRC8_POLY        = 8'h07;

endpackage

// File: rtl/crc_stream_engine_if.sv
// crc_stream_engine_if: message-word valid/ready stream.
// master drives data/valid/last, slave returns ready.
interface crc_stream_engine_if #(
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0] data_i;
  logic              data_valid_i;
  logic              data_last_i;
  logic              data_ready_o;

  modport master (
    output data_i,
    output data_valid_i,
    output data_last_i,
    input  data_ready_o
  );

  modport slave (
    input  data_i,
    input  data_valid_i,
    input  data_last_i,
    output data_ready_o
  );

endinterface

// File: rtl/crc_stream_engine_lfsr_step.sv
// crc_lfsr_step: folds BPC message bits into a CRC register.
// Ports: crc_i/poly_i current state and polynomial, bits_i bits, crc_o next.
module crc_lfsr_step #(
  parameter int CRC_W = 32,
  parameter int BPC   = 1
) (
  input  logic [CRC_W-1:0] crc_i,
  input  logic [CRC_W-1:0] poly_i,
  input  logic [BPC-1:0]   bits_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] c;
  logic             fb;

  // bits_i[BPC-1] is the oldest bit and is folded first.
  always_comb begin
    c  = crc_i;
    fb = 1'b0;
    for (int i = BPC - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ bits_i[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? poly_i : '0);
    end
    crc_o = c;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: configurable CRC over a valid/ready word stream.
// Ports: clk_i/rst_i, config (poly/init/xorout/refin/refout), start_i, abort_i,
// s_if word stream (slave), crc_o result, crc_valid_o pulse, busy_o.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int CRC_W  = 32,
  parameter int DATA_W = 32,
  parameter int BPC    = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CRC_W-1:0]    poly_i,
  input  logic [CRC_W-1:0]    init_i,
  input  logic [CRC_W-1:0]    xorout_i,
  input  logic                refin_i,
  input  logic                refout_i,
  input  logic                start_i,
  input  logic                abort_i,
  crc_stream_engine_if.slave  s_if,
  output logic [CRC_W-1:0]    crc_o,
  output logic                crc_valid_o,
  output logic                busy_o
);

  localparam int N     = DATA_W / BPC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  crc_state_e        state_q, state_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic [CRC_W-1:0]  poly_q, poly_d;
  logic [CRC_W-1:0]  xor_q, xor_d;
  logic [CRC_W-1:0]  out_q, out_d;
  logic              refin_q, refin_d;
  logic              refout_q, refout_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] data_rev;
  logic [CRC_W-1:0]  step_crc;
  logic [CRC_W-1:0]  step_rev;

  // Reflected words are reversed once at accept time so the
  // shift path is always MSB-first.
  always_comb begin
    for (int i = 0; i < DATA_W; i++) begin
      data_rev[i] = s_if.data_i[DATA_W-1-i];
    end
  end

  always_comb begin
    for (int i = 0; i < CRC_W; i++) begin
      step_rev[i] = step_crc[CRC_W-1-i];
    end
  end

  crc_lfsr_step #(
    .CRC_W (CRC_W),
    .BPC   (BPC)
  ) u_step (
    .crc_i  (crc_q),
    .poly_i (poly_q),
    .bits_i (data_q[DATA_W-1 -: BPC]),
    .crc_o  (step_crc)
  );

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    poly_d   = poly_q;
    xor_d    = xor_q;
    out_d    = out_q;
    refin_d  = refin_q;
    refout_d = refout_q;
    last_d   = last_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_i) begin
          poly_d   = poly_i;
          xor_d    = xorout_i;
          refin_d  = refin_i;
          refout_d = refout_i;
          crc_d    = init_i;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (s_if.data_valid_i) begin
          data_d  = refin_q ? data_rev : s_if.data_i;
          last_d  = s_if.data_last_i;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        crc_d  = step_crc;
        data_d = data_q << BPC;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = last_q ? DONE : WAIT;
          if (last_q) begin
            out_d = (refout_q ? step_rev : step_crc) ^ xor_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // An abort also suppresses a result landing on the same edge.
    if (abort_i) begin
      state_d = IDLE;
      out_d   = out_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      crc_q    <= '0;
      poly_q   <= '0;
      xor_q    <= '0;
      out_q    <= '0;
      refin_q  <= 1'b0;
      refout_q <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      poly_q   <= poly_d;
      xor_q    <= xor_d;
      out_q    <= out_d;
      refin_q  <= refin_d;
      refout_q <= refout_d;
      last_q   <= last_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign s_if.data_ready_o = (state_q == WAIT);
  assign busy_o            = (state_q == WAIT) || (state_q == SHIFT);
  assign crc_valid_o       = (state_q == DONE);
  assign crc_o             = out_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine: randomized scoreboard bench for crc_stream_engine.
// Three instances: 32/8/1, 16/32/8 and 16/8/1 (tail cross-check).
module tb_crc_stream_engine;
  import crc_pkg::*;

  localparam int NA = 8;
  localparam int NB = 4;
  localparam int NC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- instance A: CRC_W=32 DATA_W=8 BPC=1
  logic [31:0] a_poly, a_init, a_xor, a_crc;
  logic        a_refin, a_refout, a_start, a_abort;
  logic        a_vld, a_busy;
  crc_stream_engine_if #(.DATA_W(8)) a_if ();

  crc_stream_engine #(.CRC_W(32), .DATA_W(8), .BPC(1)) u_a (
    .clk_i(clk), .rst_i(rst),
    .poly_i(a_poly), .init_i(a_init), .xorout_i(a_xor),
    .refin_i(a_refin), .refout_i(a_refout),
    .start_i(a_start), .abort_i(a_abort),
    .s_if(a_if.slave),
    .crc_o(a_crc), .crc_valid_o(a_vld), .busy_o(a_busy)
  );

  // ---------------- instance B: CRC_W=16 DATA_W=32 BPC=8
  logic [15:0] b_poly, b_init, b_xor, b_crc;
  logic        b_refin, b_refout, b_start, b_abort;
  logic        b_vld, b_busy;
  crc_stream_engine_if #(.DATA_W(32)) b_if ();

  crc_stream_engine #(.CRC_W(16), .DATA_W(32), .BPC(8)) u_b (
    .clk_i(clk), .rst_i(rst),
    .poly_i(b_poly), .init_i(b_init), .xorout_i(b_xor),
    .refin_i(b_refin), .refout_i(b_refout),
    .start_i(b_start), .abort_i(b_abort),
    .s_if(b_if.slave),
    .crc_o(b_crc), .crc_valid_o(b_vld), .busy_o(b_busy)
  );

  // ---------------- instance C: CRC_W=16 DATA_W=8 BPC=1
  logic [15:0] c_poly, c_init, c_xor, c_crc;
  logic        c_refin, c_refout, c_start, c_abort;
  logic        c_vld, c_busy;
  crc_stream_engine_if #(.DATA_W(8)) c_if ();

  crc_stream_engine #(.CRC_W(16), .DATA_W(8), .BPC(1)) u_c (
    .clk_i(clk), .rst_i(rst),
    .poly_i(c_poly), .init_i(c_init), .xorout_i(c_xor),
    .refin_i(c_refin), .refout_i(c_refout),
    .start_i(c_start), .abort_i(c_abort),
    .s_if(c_if.slave),
    .crc_o(c_crc), .crc_valid_o(c_vld), .busy_o(c_busy)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Textbook bit-serial CRC over a list of words.
  function automatic logic [31:0] ref_crc(
    int w, int dw, logic [31:0] poly, logic [31:0] init,
    logic [31:0] xo, bit ri, bit ro, logic [31:0] msg[$]);
    logic [31:0] mask, r, o;
    bit b, top;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 1);
    r = init & mask;
    foreach (msg[j]) begin
      for (int k = 0; k < dw; k++) begin
        b   = ri ? msg[j][k] : msg[j][dw-1-k];
        top = r[w-1];
        r   = (r << 1) & mask;
        if (top ^ b) r = r ^ (poly & mask);
      end
    end
    o = r;
    if (ro) begin
      o = '0;
      for (int k = 0; k < w; k++) o[w-1-k] = r[k];
    end
    return (o ^ xo) & mask;
  endfunction

  // ---------------- scoreboards / monitors
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qc[$];
  int ta_acc = 0, tb_acc = 0, tc_acc = 0;
  bit pa = 0, pb = 0, pc = 0;

  always @(negedge clk) begin
    if (a_vld) begin
      chk("a_single_pulse", pa, 0);
      if (qa.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected_valid: crc_o=%h with no result pending", a_crc);
      end else begin
        chk("a_crc", a_crc, qa.pop_front());
        chk("a_latency", cyc, ta_acc + NA);
      end
    end
    pa = a_vld;
  end

  always @(negedge clk) begin
    if (b_vld) begin
      chk("b_single_pulse", pb, 0);
      if (qb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected_valid: crc_o=%h with no result pending", b_crc);
      end else begin
        chk("b_crc", b_crc, qb.pop_front());
        chk("b_latency", cyc, tb_acc + NB);
      end
    end
    pb = b_vld;
  end

  always @(negedge clk) begin
    if (c_vld) begin
      chk("c_single_pulse", pc, 0);
      if (qc.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL c_unexpected_valid: crc_o=%h with no result pending", c_crc);
      end else begin
        chk("c_crc", c_crc, qc.pop_front());
        chk("c_latency", cyc, tc_acc + NC);
      end
    end
    pc = c_vld;
  end

  // ---------------- instance A driver (tasks live on negedges)
  task automatic start_a(logic [31:0] p, logic [31:0] i,
                         logic [31:0] x, bit ri, bit ro);
    a_poly = p; a_init = i; a_xor = x;
    a_refin = ri; a_refout = ro; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_poly = $urandom; a_init = $urandom; a_xor = $urandom;
    a_refin = 1'($urandom); a_refout = 1'($urandom);
    chk("a_ready_after_start", a_if.data_ready_o, 1);
    chk("a_busy_after_start", a_busy, 1);
  endtask

  task automatic words_a(logic [31:0] msg[$], bit glitch);
    foreach (msg[j]) begin
      bit acc;
      int g;
      acc = 0; g = 0;
      a_if.data_i = msg[j][7:0];
      a_if.data_last_i = (j == msg.size() - 1);
      while (!acc && g < 40) begin
        a_if.data_valid_i = ($urandom_range(0, 2) != 0) || (g > 6);
        acc = a_if.data_valid_i && a_if.data_ready_o;
        @(negedge clk);
        g++;
      end
      a_if.data_valid_i = 1'b0;
      if (!acc) begin
        chk("a_accept_timeout", 0, 1);
        return;
      end
      ta_acc = cyc;
      a_if.data_i = 8'($urandom);
      a_if.data_last_i = 1'($urandom);
      if (j != msg.size() - 1) begin
        g = 0;
        while (!a_if.data_ready_o && g < NA + 4) begin
          a_start = glitch && (g == 2);
          @(negedge clk);
          g++;
        end
        a_start = 1'b0;
        chk("a_ready_gap", g, NA);
      end
    end
  endtask

  task automatic wait_done_a();
    int g;
    g = 0;
    while (!a_vld && g < NA + 4) begin
      @(negedge clk);
      g++;
    end
    chk("a_done_seen", a_vld, 1);
  endtask

  // ---------------- instance B driver
  task automatic start_b(logic [15:0] p, logic [15:0] i,
                         logic [15:0] x, bit ri, bit ro);
    b_poly = p; b_init = i; b_xor = x;
    b_refin = ri; b_refout = ro; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_poly = 16'($urandom); b_init = 16'($urandom);
    chk("b_ready_after_start", b_if.data_ready_o, 1);
  endtask

  task automatic words_b(logic [31:0] msg[$]);
    foreach (msg[j]) begin
      bit acc;
      int g;
      acc = 0; g = 0;
      b_if.data_i = msg[j];
      b_if.data_last_i = (j == msg.size() - 1);
      while (!acc && g < 40) begin
        b_if.data_valid_i = ($urandom_range(0, 1) != 0) || (g > 6);
        acc = b_if.data_valid_i && b_if.data_ready_o;
        @(negedge clk);
        g++;
      end
      b_if.data_valid_i = 1'b0;
      if (!acc) begin
        chk("b_accept_timeout", 0, 1);
        return;
      end
      tb_acc = cyc;
      b_if.data_i = $urandom;
      if (j != msg.size() - 1) begin
        g = 0;
        while (!b_if.data_ready_o && g < NB + 4) begin
          @(negedge clk);
          g++;
        end
        chk("b_ready_gap", g, NB);
      end
    end
  endtask

  task automatic wait_done_b();
    int g;
    g = 0;
    while (!b_vld && g < NB + 4) begin
      @(negedge clk);
      g++;
    end
    chk("b_done_seen", b_vld, 1);
  endtask

  // ---------------- instance C: single-byte message
  task automatic run_c(logic [15:0] init, logic [7:0] byt);
    int g;
    c_poly = CRC16_CCITT_POLY; c_init = init; c_xor = '0;
    c_refin = 1'b0; c_refout = 1'b0; c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    c_if.data_i = byt; c_if.data_last_i = 1'b1;
    c_if.data_valid_i = 1'b1;
    chk("c_ready_after_start", c_if.data_ready_o, 1);
    @(negedge clk);
    tc_acc = cyc;
    c_if.data_valid_i = 1'b0;
    g = 0;
    while (!c_vld && g < NC + 4) begin
      @(negedge clk);
      g++;
    end
    chk("c_done_seen", c_vld, 1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] m9[$];
    logic [31:0] mb[$];
    logic [31:0] m[$];
    logic [31:0] p, i, x, r16;
    bit ri, ro;

    m9 = '{32'h31, 32'h32, 32'h33, 32'h34, 32'h35,
           32'h36, 32'h37, 32'h38, 32'h39};

    rst = 1'b1;
    {a_poly, a_init, a_xor, a_refin, a_refout, a_start, a_abort} = '0;
    {b_poly, b_init, b_xor, b_refin, b_refout, b_start, b_abort} = '0;
    {c_poly, c_init, c_xor, c_refin, c_refout, c_start, c_abort} = '0;
    a_if.data_i = '0; a_if.data_valid_i = 0; a_if.data_last_i = 0;
    b_if.data_i = '0; b_if.data_valid_i = 0; b_if.data_last_i = 0;
    c_if.data_i = '0; c_if.data_valid_i = 0; c_if.data_last_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_a_crc", a_crc, 0);
    chk("rst_a_valid", a_vld, 0);
    chk("rst_a_ready", a_if.data_ready_o, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_b_crc", b_crc, 0);
    chk("rst_b_ready", b_if.data_ready_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // CRC-32, start ignored mid-SHIFT
    qa.push_back(32'hCBF4_3926);
    start_a(CRC32_POLY, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1);
    words_a(m9, 1);
    wait_done_a();

    // CRC-32/MPEG-2, started in the DONE cycle
    qa.push_back(32'h0376_E6E7);
    start_a(CRC32_POLY, 32'hFFFF_FFFF, 32'h0, 0, 0);
    words_a(m9, 0);
    wait_done_a();
    @(negedge clk);

    // abort in SHIFT mid-message
    start_a(CRC32_POLY, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1);
    a_if.data_i = 8'h31; a_if.data_last_i = 1'b0;
    a_if.data_valid_i = 1'b1;
    @(negedge clk);
    a_if.data_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_busy", a_busy, 1);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    chk("abort_busy", a_busy, 0);
    chk("abort_ready", a_if.data_ready_o, 0);
    chk("abort_valid", a_vld, 0);
    chk("abort_crc_held", a_crc, 32'h0376_E6E7);
    // abort wins over start
    a_abort = 1'b1; a_start = 1'b1;
    @(negedge clk);
    a_abort = 1'b0; a_start = 1'b0;
    chk("abort_over_start", a_if.data_ready_o, 0);
    repeat (NA + 2) @(negedge clk);

    qa.push_back(32'hCBF4_3926);
    start_a(CRC32_POLY, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1);
    words_a(m9, 0);
    wait_done_a();
    @(negedge clk);

    // randomized CRC_W=32 messages
    for (int t = 0; t < 30; t++) begin
      p = $urandom; i = $urandom; x = $urandom;
      ri = 1'($urandom); ro = 1'($urandom);
      m.delete();
      for (int k = 0; k < $urandom_range(1, 6); k++)
        m.push_back({24'h0, 8'($urandom)});
      qa.push_back(ref_crc(32, 8, p, i, x, ri, ro, m));
      start_a(p, i, x, ri, ro);
      words_a(m, 1'($urandom));
      wait_done_a();
      if ($urandom_range(0, 1) != 0) @(negedge clk);
    end
    @(negedge clk);

    // CRC-16/CCITT-FALSE: 32-bit words then 8-bit tail
    mb = '{32'h3132_3334, 32'h3536_3738};
    r16 = ref_crc(16, 32, 32'h1021, 32'hFFFF, 32'h0, 0, 0, mb);
    qb.push_back(r16);
    start_b(CRC16_CCITT_POLY, 16'hFFFF, 16'h0, 0, 0);
    words_b(mb);
    wait_done_b();
    @(negedge clk);
    qc.push_back(32'h29B1);
    run_c(r16[15:0], 8'h39);

    // randomized CRC_W=16, 32-bit words, 8 bits per cycle
    for (int t = 0; t < 15; t++) begin
      p = $urandom; i = $urandom; x = $urandom;
      ri = 1'($urandom); ro = 1'($urandom);
      m.delete();
      for (int k = 0; k < $urandom_range(1, 4); k++)
        m.push_back($urandom);
      qb.push_back(ref_crc(16, 32, p, i, x, ri, ro, m));
      start_b(p[15:0], i[15:0], x[15:0], ri, ro);
      words_b(m);
      wait_done_b();
      if ($urandom_range(0, 1) != 0) @(negedge clk);
    end
    @(negedge clk);

    // reset while waiting for a word
    start_a(CRC32_POLY, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait_crc", a_crc, 0);
    chk("rst_wait_ready", a_if.data_ready_o, 0);
    chk("rst_wait_busy", a_busy, 0);
    chk("rst_wait_valid", a_vld, 0);

    repeat (NA + 4) @(negedge clk);
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    chk("c_queue_empty", qc.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
